// File: rtl/ahb_apb_pkg.sv
// Shared types and address map for the AHB-to-APB bridge controller.
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_RENABLE  = 3'd2,
    ST_WWAIT    = 3'd3,
    ST_WRITE    = 3'd4,
    ST_WRITEP   = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } state_e;

  localparam logic [2:0] PSEL_NONE = 3'b000;

  localparam logic [31:0] S0_BASE  = 32'h8000_0000;
  localparam logic [31:0] S0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] S1_BASE  = 32'h8400_0000;
  localparam logic [31:0] S1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] S2_BASE  = 32'h8800_0000;
  localparam logic [31:0] S2_LIMIT = 32'h8C00_0000;

  // Limits are inclusive; the last slave deliberately owns 0x8C00_0000 itself.
  function automatic logic [2:0] decode(input logic [31:0] addr);
    logic [2:0] sel;
    sel = PSEL_NONE;
    if (addr >= S0_BASE && addr <= S0_LIMIT)      sel = 3'b001;
    else if (addr >= S1_BASE && addr <= S1_LIMIT) sel = 3'b010;
    else if (addr >= S2_BASE && addr <= S2_LIMIT) sel = 3'b100;
    return sel;
  endfunction

endpackage

// File: rtl/apb_fsm_controller.sv
// AHB-to-APB bridge sequencer: drives APB3 SETUP/ACCESS phases and stalls AHB via hreadyout.
// Build option APB_PREADY_EN: ACCESS phases stretch until pready; otherwise pready is ignored.
module apb_fsm_controller
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              valid,
  input  logic              hwrite,
  input  logic              hwrite_reg,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [ADDR_W-1:0] haddr1,
  input  logic [ADDR_W-1:0] haddr2,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hwdata1,
  input  logic [2:0]        temp_selx,
  input  logic              pready,
  output logic [2:0]        pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              hreadyout
);

  state_e state;
  state_e next_state;
  logic   access_done;
  logic   access_ready;

`ifdef APB_PREADY_EN
  assign access_done  = pready;
  assign access_ready = 1'b0;
`else
  logic unused_pready;
  assign unused_pready = pready;
  assign access_done   = 1'b1;
  assign access_ready  = 1'b1;
`endif

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (valid) next_state = hwrite ? ST_WWAIT : ST_READ;
      end
      ST_READ:   next_state = ST_RENABLE;
      ST_RENABLE, ST_WENABLE: begin
        if (access_done) begin
          if (!valid)      next_state = ST_IDLE;
          else if (hwrite) next_state = ST_WWAIT;
          else             next_state = ST_READ;
        end
      end
      ST_WWAIT:  next_state = valid ? ST_WRITEP : ST_WRITE;
      ST_WRITE:  next_state = valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP: next_state = ST_WENABLEP;
      ST_WENABLEP: begin
        // a read caught behind a pipelined write is launched straight from the access phase
        if (access_done) begin
          if (!hwrite_reg) next_state = ST_READ;
          else if (valid)  next_state = ST_WRITEP;
          else             next_state = ST_WRITE;
        end
      end
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= ST_IDLE;
      pselx     <= PSEL_NONE;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      hreadyout <= 1'b1;
    end else begin
      state <= next_state;
      case (next_state)
        ST_READ: begin
          paddr     <= haddr;
          pselx     <= temp_selx;
          pwrite    <= 1'b0;
          penable   <= 1'b0;
          hreadyout <= 1'b0;
        end
        ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
          penable   <= 1'b1;
          hreadyout <= access_ready;
        end
        ST_WWAIT: begin
          pselx     <= PSEL_NONE;
          penable   <= 1'b0;
          hreadyout <= 1'b1;
        end
        ST_WRITE, ST_WRITEP: begin
          // coming out of a pipelined access, the pending beat sits one stage further back
          if (state == ST_WENABLEP) begin
            paddr  <= haddr2;
            pwdata <= hwdata1;
            pselx  <= decode(32'(haddr2));
          end else begin
            paddr  <= haddr1;
            pwdata <= hwdata;
            pselx  <= decode(32'(haddr1));
          end
          pwrite    <= 1'b1;
          penable   <= 1'b0;
          hreadyout <= 1'b0;
        end
        default: begin
          pselx     <= PSEL_NONE;
          penable   <= 1'b0;
          hreadyout <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Bench for apb_fsm_controller: an AHB master model feeds requests, an APB monitor checks transfers.
module tb_apb_fsm_controller;

  logic        hclk = 1'b0;
  logic        hreset, valid, hwrite, hwrite_reg, pready;
  logic [31:0] haddr, haddr1, haddr2, hwdata, hwdata1;
  logic [2:0]  temp_selx, pselx;
  logic        penable, pwrite, hreadyout;
  logic [31:0] paddr, pwdata;

  always #5 hclk = ~hclk;

  apb_fsm_controller #(.ADDR_W(32), .DATA_W(32)) dut (
    .hclk(hclk), .hreset(hreset), .valid(valid), .hwrite(hwrite), .hwrite_reg(hwrite_reg),
    .haddr(haddr), .haddr1(haddr1), .haddr2(haddr2), .hwdata(hwdata), .hwdata1(hwdata1),
    .temp_selx(temp_selx), .pready(pready), .pselx(pselx), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .hreadyout(hreadyout)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
  } xfer_t;

  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  xfer_t pend[$];
  xfer_t exp_q[$];
  int    setup_cycles[$];
  xfer_t snap;
  logic  prev_setup, prev_pen;

  function automatic logic [2:0] ref_sel(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a < 32'h8400_0000) return 3'b001;
    if (a >= 32'h8400_0000 && a < 32'h8800_0000) return 3'b010;
    if (a >= 32'h8800_0000 && a <= 32'h8C00_0000) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [31:0] rand_addr(input bit wr);
    int unsigned r;
    r = $urandom_range(0, wr ? 4 : 3);
    case (r)
      0: return 32'h8000_0000 + ($urandom_range(0, 32'h00FF_FFFF) << 2);
      1: return 32'h8400_0000 + ($urandom_range(0, 32'h00FF_FFFF) << 2);
      2: return 32'h8800_0000 + ($urandom_range(0, 32'h00FF_FFFF) << 2);
      3: begin
        r = $urandom_range(0, 2);
        if (r == 0) return 32'h83FF_FFFC;
        if (r == 1) return 32'h8400_0000;
        return 32'h8C00_0000;
      end
      default: begin
        r = $urandom_range(0, 2);
        if (r == 0) return 32'h8C00_0004;
        if (r == 1) return 32'h7FFF_FFFC;
        return 32'h9000_0000;
      end
    endcase
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic w);
    xfer_t x;
    x.addr = a;
    x.data = d;
    x.wr   = w;
    pend.push_back(x);
  endtask

  // The master holds address and direction when it has nothing to issue.
  task automatic present();
    if (pend.size() > 0) begin
      valid  = 1'b1;
      haddr  = pend[0].addr;
      hwrite = pend[0].wr;
    end else begin
      valid = 1'b0;
    end
    temp_selx = ref_sel(haddr);
  endtask

  task automatic monitor();
    logic is_setup;
    is_setup = !penable && !hreadyout;
    if (prev_setup) cmp("access_after_setup", 32'(penable), 32'd1);
    if (penable) begin
      cmp("hold_paddr", paddr, snap.addr);
      cmp("hold_pselx", 32'(pselx), 32'(ref_sel(snap.addr)));
      cmp("hold_pwrite", 32'(pwrite), 32'(snap.wr));
      if (snap.wr) cmp("hold_pwdata", pwdata, snap.data);
`ifndef APB_PREADY_EN
      cmp("penable_single", 32'(prev_pen), 32'd0);
`endif
    end
    if (is_setup) begin
      setup_cycles.push_back(cyc);
      cmp("setup_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        snap = exp_q.pop_front();
        cmp("setup_paddr", paddr, snap.addr);
        cmp("setup_pselx", 32'(pselx), 32'(ref_sel(snap.addr)));
        cmp("setup_pwrite", 32'(pwrite), 32'(snap.wr));
        if (snap.wr) cmp("setup_pwdata", pwdata, snap.data);
      end
    end
    prev_setup = is_setup;
    prev_pen   = penable;
  endtask

  task automatic step();
    logic hr_cyc, rst_cyc;
    hr_cyc  = hreadyout;
    rst_cyc = hreset;
`ifndef APB_PREADY_EN
    pready = 1'($urandom_range(0, 1));
`endif
    @(posedge hclk);
    #1;
    cyc++;
    hwrite_reg = hwrite;
    haddr2     = haddr1;
    haddr1     = haddr;
    hwdata1    = hwdata;
    if (!rst_cyc && valid && hr_cyc) begin
      exp_q.push_back(pend[0]);
      if (pend[0].wr) hwdata = pend[0].data;
      pend.delete(0);
    end
    present();
    if (rst_cyc) begin
      prev_setup = 1'b0;
      prev_pen   = 1'b0;
    end else begin
      monitor();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (pend.size() > 0 && n < 60) begin
      step();
      n++;
    end
    cmp("drain_timeout", 32'(pend.size()), 32'd0);
    repeat (7) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    cmp({tag, "_hreadyout"}, 32'(hreadyout), 32'd1);
    cmp({tag, "_pselx"}, 32'(pselx), 32'd0);
    cmp({tag, "_penable"}, 32'(penable), 32'd0);
    cmp({tag, "_pwrite"}, 32'(pwrite), 32'd0);
    cmp({tag, "_paddr"}, paddr, 32'd0);
    cmp({tag, "_pwdata"}, pwdata, 32'd0);
  endtask

  initial begin
    int c0;
    hreset = 1'b1; valid = 1'b0; hwrite = 1'b0; hwrite_reg = 1'b0;
    haddr = '0; haddr1 = '0; haddr2 = '0; hwdata = '0; hwdata1 = '0;
    temp_selx = '0; pready = 1'b1; prev_setup = 1'b0; prev_pen = 1'b0;
    snap.addr = '0; snap.data = '0; snap.wr = 1'b0;

    step();
    step();
    check_reset_outputs("rst");
    hreset = 1'b0;
    step();

`ifndef APB_PREADY_EN
    // single read
    enq(32'h8000_0010, 32'h0, 1'b0);
    present();
    step();
    cmp("rd_pselx", 32'(pselx), 32'b001);
    cmp("rd_paddr", paddr, 32'h8000_0010);
    cmp("rd_pwrite", 32'(pwrite), 32'd0);
    cmp("rd_setup_penable", 32'(penable), 32'd0);
    cmp("rd_setup_hready", 32'(hreadyout), 32'd0);
    step();
    cmp("rd_access_penable", 32'(penable), 32'd1);
    cmp("rd_access_hready", 32'(hreadyout), 32'd1);
    step();
    cmp("rd_idle_pselx", 32'(pselx), 32'd0);
    cmp("rd_idle_penable", 32'(penable), 32'd0);
    cmp("rd_idle_hready", 32'(hreadyout), 32'd1);
    repeat (2) step();

    // single write
    enq(32'h8400_0004, 32'hDEAD_BEEF, 1'b1);
    present();
    step();
    cmp("wr_wwait_pselx", 32'(pselx), 32'd0);
    cmp("wr_wwait_penable", 32'(penable), 32'd0);
    cmp("wr_wwait_hready", 32'(hreadyout), 32'd1);
    step();
    cmp("wr_pselx", 32'(pselx), 32'b010);
    cmp("wr_pwrite", 32'(pwrite), 32'd1);
    cmp("wr_pwdata", pwdata, 32'hDEAD_BEEF);
    cmp("wr_paddr", paddr, 32'h8400_0004);
    step();
    cmp("wr_access_penable", 32'(penable), 32'd1);
    repeat (3) step();

    // four back-to-back writes
    for (int i = 0; i < 4; i++) enq(32'h8800_0000 + 32'(4 * i), $urandom(), 1'b1);
    present();
    c0 = cyc;
    setup_cycles.delete();
    drain();
    cmp("burst_setups", 32'(setup_cycles.size()), 32'd4);
    for (int i = 0; i < 4 && i < setup_cycles.size(); i++)
      cmp("burst_setup_cycle", 32'(setup_cycles[i] - c0), 32'(2 + 2 * i));

    // write then read
    enq(32'h8000_0000, 32'h1234_5678, 1'b1);
    enq(32'h8400_0000, 32'h0, 1'b0);
    present();
    c0 = cyc;
    setup_cycles.delete();
    drain();
    cmp("wr_rd_setups", 32'(setup_cycles.size()), 32'd2);
    if (setup_cycles.size() == 2) begin
      cmp("wr_rd_write_setup", 32'(setup_cycles[0] - c0), 32'd2);
      cmp("wr_rd_read_setup", 32'(setup_cycles[1] - c0), 32'd4);
    end

    // decode boundaries and unmapped write
    enq(32'h8C00_0000, 32'hA5A5_0001, 1'b1); present(); drain();
    enq(32'h8C00_0004, 32'hA5A5_0002, 1'b1); present(); drain();
    enq(32'h83FF_FFFC, 32'h0, 1'b0);         present(); drain();

    // randomized request mixes
    for (int s = 0; s < 40; s++) begin
      int nr, nw, kind;
      nr   = int'($urandom_range(0, 2));
      kind = int'($urandom_range(0, 3));
      for (int i = 0; i < nr; i++) enq(rand_addr(1'b0), 32'h0, 1'b0);
      if (kind == 0) begin
        enq(rand_addr(1'b1), $urandom(), 1'b1);
        enq(rand_addr(1'b0), 32'h0, 1'b0);
      end else begin
        nw = int'($urandom_range((nr == 0) ? 1 : 0, 4));
        for (int i = 0; i < nw; i++) enq(rand_addr(1'b1), $urandom(), 1'b1);
      end
      present();
      drain();
    end

    // reset during an access phase
    enq(32'h8400_0008, 32'hCAFE_F00D, 1'b1);
    present();
    step();
    step();
    step();
    cmp("abort_penable", 32'(penable), 32'd1);
    hreset = 1'b1;
    step();
    check_reset_outputs("abort");
    hreset = 1'b0;
    exp_q.delete();
    step();
    cmp("abort_idle_hready", 32'(hreadyout), 32'd1);
`else
    // read with pready low for three cycles of the access phase
    enq(32'h8000_0010, 32'h0, 1'b0);
    present();
    step();
    cmp("ws_setup_hready", 32'(hreadyout), 32'd0);
    pready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      cmp("ws_penable", 32'(penable), 32'd1);
      cmp("ws_hready", 32'(hreadyout), 32'd0);
      if (i == 3) pready = 1'b1;
    end
    step();
    cmp("ws_done_penable", 32'(penable), 32'd0);
    cmp("ws_done_hready", 32'(hreadyout), 32'd1);
    repeat (2) step();

    // reset during a stretched write access
    enq(32'h8400_0008, 32'hCAFE_F00D, 1'b1);
    present();
    step();
    step();
    pready = 1'b0;
    step();
    step();
    cmp("abort_penable", 32'(penable), 32'd1);
    cmp("abort_hready", 32'(hreadyout), 32'd0);
    hreset = 1'b1;
    step();
    check_reset_outputs("abort");
    hreset = 1'b0;
    pready = 1'b1;
    exp_q.delete();
    step();
    cmp("abort_idle_hready", 32'(hreadyout), 32'd1);
`endif

    cmp("all_transfers_seen", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
